// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder for the RV32 R-type set, with an iterative M-extension sequencer.
// The sequencer does radix-2 shift-add multiply and restoring divide, one step per cycle, and stalls EX until its result is ready.
module alu_ctrl_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [3:0]      ALUCtrl_o,
  output logic            md_stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam logic [3:0] CTRL_ADD  = 4'b0001;
  localparam logic [3:0] CTRL_SUB  = 4'b0010;
  localparam logic [3:0] CTRL_AND  = 4'b0011;
  localparam logic [3:0] CTRL_OR   = 4'b0100;
  localparam logic [3:0] CTRL_XOR  = 4'b0101;
  localparam logic [3:0] CTRL_SLL  = 4'b0111;
  localparam logic [3:0] CTRL_SRL  = 4'b1000;
  localparam logic [3:0] CTRL_SRA  = 4'b1001;
  localparam logic [3:0] CTRL_SLT  = 4'b1010;
  localparam logic [3:0] CTRL_SLTU = 4'b1011;
  localparam logic [3:0] CTRL_MD   = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [6:0]          funct7;
  logic [2:0]          funct3;
  logic                isMd, isDiv, aSigned, bSigned, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                divByZero, divOverflow;
  logic [XLEN-1:0]     specialResult;
  logic [XLEN:0]       mulSum, divTrial;
  logic [2*XLEN-1:0]   stepProd, prodSel;
  logic [XLEN-1:0]     divSel, finalResult;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];

  always_comb begin
    ALUCtrl_o = CTRL_ADD;
    case (ALUOp_i)
      2'b01: ALUCtrl_o = CTRL_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: ALUCtrl_o = CTRL_ADD;
            3'b001: ALUCtrl_o = CTRL_SLL;
            3'b010: ALUCtrl_o = CTRL_SLT;
            3'b011: ALUCtrl_o = CTRL_SLTU;
            3'b100: ALUCtrl_o = CTRL_XOR;
            3'b101: ALUCtrl_o = CTRL_SRL;
            3'b110: ALUCtrl_o = CTRL_OR;
            3'b111: ALUCtrl_o = CTRL_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      ALUCtrl_o = CTRL_SUB;
          else if (funct3 == 3'b101) ALUCtrl_o = CTRL_SRA;
        end else if (funct7 == 7'b0000001) begin
          ALUCtrl_o = CTRL_MD;
        end
      end
      default: ALUCtrl_o = CTRL_ADD;
    endcase
  end

  assign isMd    = valid_i & (ALUOp_i == 2'b10) & (funct7 == 7'b0000001);
  assign isDiv   = funct3[2];
  // MULH/MULHSU/DIV/REM treat src1 as signed; only MULH/DIV/REM treat src2 as signed
  assign aSigned = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign bSigned = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign neg1    = aSigned & src1_i[XLEN-1];
  assign neg2    = bSigned & src2_i[XLEN-1];
  assign mag1    = neg1 ? -src1_i : src1_i;
  assign mag2    = neg2 ? -src2_i : src2_i;

  assign divByZero   = isDiv & (src2_i == '0);
  assign divOverflow = isDiv & ~funct3[0] & (src1_i == MOST_NEG) & (&src2_i);
  assign specialResult = divByZero ? (funct3[1] ? src1_i : '1)
                                   : (funct3[1] ? '0 : src1_i);

  // Product register doubles as {remainder, quotient} while dividing
  always_comb begin
    mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({(XLEN+1){prod_q[0]}} & {1'b0, opnd_q});
    divTrial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (!op_q[2])
      stepProd = {mulSum, prod_q[XLEN-1:1]};
    else if (!divTrial[XLEN])
      stepProd = {divTrial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else
      stepProd = {prod_q[2*XLEN-2:0], 1'b0};

    prodSel = neg_q ? -stepProd : stepProd;
    divSel  = op_q[1] ? stepProd[2*XLEN-1:XLEN] : stepProd[XLEN-1:0];
    if (!op_q[2])
      finalResult = (op_q[1:0] == 2'b00) ? prodSel[XLEN-1:0] : prodSel[2*XLEN-1:XLEN];
    else
      finalResult = neg_q ? -divSel : divSel;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (isMd) begin
          if (divByZero | divOverflow) begin
            state_d  = DONE;
            result_d = specialResult;
          end else begin
            state_d = CALC;
            op_d    = funct3;
            neg_d   = (isDiv & funct3[1]) ? neg1 : (neg1 ^ neg2);
            opnd_d  = isDiv ? mag2 : mag1;
            prod_d  = {{XLEN{1'b0}}, (isDiv ? mag1 : mag2)};
            cnt_d   = CNT_INIT;
          end
        end
      end
      CALC: begin
        prod_d = stepProd;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = finalResult;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign md_done_o   = (state_q == DONE);
  assign md_stall_o  = isMd & ~md_done_o;
  assign md_result_o = result_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, M-op results and latency,
// division special cases, flush and reset aborts.
module tb_alu_ctrl_muldiv;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  logic            clk_i;
  logic            rst_i;
  logic            valid_i;
  logic [9:0]      funct_i;
  logic [1:0]      ALUOp_i;
  logic            flush_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic [3:0]      ALUCtrl_o;
  logic            md_stall_o;
  logic            md_done_o;
  logic [XLEN-1:0] md_result_o;

  int checks = 0;
  int errors = 0;

  alu_ctrl_muldiv #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .funct_i     (funct_i),
    .ALUOp_i     (ALUOp_i),
    .flush_i     (flush_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .ALUCtrl_o   (ALUCtrl_o),
    .md_stall_o  (md_stall_o),
    .md_done_o   (md_done_o),
    .md_result_o (md_result_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic applyStimulus(input logic v, input logic [9:0] f, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    valid_i = v;
    funct_i = f;
    ALUOp_i = op;
    src1_i  = a;
    src2_i  = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkDecode(input string tag, input logic [1:0] op, input logic [9:0] f,
                             input logic [3:0] exp);
    @(negedge clk_i);
    applyStimulus(1'b0, f, op, 32'd0, 32'd0);
    #1;
    checkOutput(tag, {28'd0, ALUCtrl_o}, {28'd0, exp});
  endtask

  // Issues one M-op in the next cycle (cycle 0) and holds it until md_done_o
  task automatic runMd(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expDone);
    int doneAt;
    logic stallOk;
    doneAt  = -1;
    stallOk = 1'b1;
    @(negedge clk_i);
    applyStimulus(1'b1, {7'b0000001, f3}, 2'b10, a, b);
    for (int c = 0; c < 60; c++) begin
      #1;
      if (md_done_o) begin
        doneAt = c;
        break;
      end
      if (md_stall_o !== 1'b1) stallOk = 1'b0;
      @(negedge clk_i);
    end
    checkOutput({tag, "_done_cycle"}, 32'(doneAt), 32'(expDone));
    checkOutput({tag, "_stall_before_done"}, {31'd0, stallOk}, 32'd1);
    checkOutput({tag, "_stall_at_done"}, {31'd0, md_stall_o}, 32'd0);
    checkOutput({tag, "_result"}, md_result_o, expRes);
  endtask

  initial begin
    int pulses;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    applyStimulus(1'b0, 10'd0, 2'b00, 32'd0, 32'd0);
    repeat (2) @(negedge clk_i);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_done", {31'd0, md_done_o}, 32'd0);
    checkOutput("rst_stall", {31'd0, md_stall_o}, 32'd0);
    checkOutput("rst_result", md_result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] decode sweep");
    checkDecode("dec_sub_r",   2'b10, {7'b0100000, 3'b000}, 4'b0010);
    checkDecode("dec_and",     2'b10, {7'b0000000, 3'b111}, 4'b0011);
    checkDecode("dec_sra",     2'b10, {7'b0100000, 3'b101}, 4'b1001);
    checkDecode("dec_md",      2'b10, {7'b0000001, 3'b011}, 4'b1111);
    checkDecode("dec_branch",  2'b01, {7'b0000000, 3'b111}, 4'b0010);
    checkDecode("dec_itype",   2'b11, {7'b0100000, 3'b000}, 4'b0001);
    checkDecode("dec_ldst",    2'b00, {7'b0000001, 3'b110}, 4'b0001);
    checkDecode("dec_bad_f7",  2'b10, {7'b1111111, 3'b000}, 4'b0001);
    checkDecode("dec_sll",     2'b10, {7'b0000000, 3'b001}, 4'b0111);
    checkDecode("dec_slt",     2'b10, {7'b0000000, 3'b010}, 4'b1010);
    checkDecode("dec_sltu",    2'b10, {7'b0000000, 3'b011}, 4'b1011);
    checkDecode("dec_xor",     2'b10, {7'b0000000, 3'b100}, 4'b0101);
    checkDecode("dec_srl",     2'b10, {7'b0000000, 3'b101}, 4'b1000);
    checkDecode("dec_or",      2'b10, {7'b0000000, 3'b110}, 4'b0100);
    checkDecode("dec_alt_or",  2'b10, {7'b0100000, 3'b110}, 4'b0001);

    $display("[TB] multiply/divide, back to back");
    runMd("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    runMd("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    runMd("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    runMd("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    runMd("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    runMd("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    runMd("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    runMd("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);

    $display("[TB] division special cases");
    runMd("div_by0",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    runMd("remu_by0", 3'b111, 32'd5,        32'd0,        32'd5,        1);
    runMd("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    runMd("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    @(negedge clk_i);
    applyStimulus(1'b0, 10'd0, 2'b00, 32'd0, 32'd0);
    #1;
    checkOutput("hold_done", {31'd0, md_done_o}, 32'd0);
    checkOutput("hold_result", md_result_o, 32'h80000000);

    $display("[TB] flush abort");
    pulses = 0;
    @(negedge clk_i);
    applyStimulus(1'b1, {7'b0000001, 3'b101}, 2'b10, 32'd100, 32'd7);
    #1;
    if (md_done_o) pulses++;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk_i);
      #1;
      if (md_done_o) pulses++;
    end
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    if (md_done_o) pulses++;
    @(negedge clk_i);
    flush_i = 1'b0;
    applyStimulus(1'b0, 10'd0, 2'b00, 32'd0, 32'd0);
    #1;
    checkOutput("flush_no_pulse", 32'(pulses), 32'd0);
    checkOutput("flush_done_low", {31'd0, md_done_o}, 32'd0);
    checkOutput("flush_result_kept", md_result_o, 32'h80000000);
    runMd("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("[TB] reset abort");
    pulses = 0;
    @(negedge clk_i);
    applyStimulus(1'b1, {7'b0000001, 3'b101}, 2'b10, 32'd100, 32'd7);
    #1;
    if (md_done_o) pulses++;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk_i);
      #1;
      if (md_done_o) pulses++;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    if (md_done_o) pulses++;
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1'b0, 10'd0, 2'b00, 32'd0, 32'd0);
    #1;
    checkOutput("rst_mid_result", md_result_o, 32'd0);
    checkOutput("rst_mid_done", {31'd0, md_done_o}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      #1;
      if (md_done_o) pulses++;
    end
    checkOutput("rst_mid_no_pulse", 32'(pulses), 32'd0);
    runMd("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Second-generation ALU control block with an embedded iterative multiply/divide sequencer.
- Decodes {funct7,funct3} and ALUOp into a widened 4-bit ALU control code covering the full RV32 R-type set.
- Executes the M-extension ops internally over multiple cycles.
- Stalls the execute stage through a combinational stall output until the result is ready.
- Sits between the main control unit/ID-EX register and the ALU; its result is muxed into the EX result path.

Parameters:
- XLEN, 32: operand/result width; must be even and at least 8.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instruction present in EX this cycle.
- funct_i  in  10  {funct7[6:0],funct3[2:0]}.
- ALUOp_i  in  2  00 add (load/store address), 01 sub (branch compare), 10 R-type decode, 11 add (I-type).
- flush_i  in  1  abort any in-flight M-op.
- src1_i  in  XLEN  rs1 operand.
- src2_i  in  XLEN  rs2 operand.
- ALUCtrl_o  out  4  ALU control code, combinational.
- md_stall_o  out  1  hold EX/upstream stages, combinational.
- md_done_o  out  1  one-cycle result-valid pulse.
- md_result_o  out  XLEN  M-op result, registered.

Behaviour:

ALUCtrl_o encoding:
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0111 SLL, 1000 SRL, 1001 SRA, 1010 SLT, 1011 SLTU, 1111 MD (ALU result unused).
- 0000, 0110, 1100-1110 are reserved and never driven.

Decode:
- ALUOp 00 or 11 -> ADD. ALUOp 01 -> SUB.
- ALUOp 10, funct7=0000000 -> by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- ALUOp 10, funct7=0100000 -> funct3 000 SUB, 101 SRA, all others ADD.
- ALUOp 10, funct7=0000001 -> MD.
- Any other funct7 -> ADD.
- Decode is purely combinational and independent of valid_i and of sequencer state.

M-op selection:
- is_md = valid_i & ALUOp_i==10 & funct7==0000001.
- funct3 selects the op: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.

Sequencer states: IDLE, CALC, DONE.
- IDLE -> CALC when is_md. On this edge, latch the op, operand magnitudes, result sign, and counter=XLEN-1.
- IDLE -> DONE directly for the division special cases:
  - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed DIV/REM with dividend=most-negative and divisor=-1: quotient = dividend; remainder = 0.
- CALC: one radix-2 step per cycle. Multiply uses shift-add into a 2*XLEN product; divide is restoring.
- CALC -> DONE when counter==0 at the step edge. On that edge, apply final negation, select low/high half or quotient/remainder, and load md_result_o.
- DONE -> IDLE unconditionally.

Outputs and timing:
- md_done_o = (state==DONE).
- md_stall_o = is_md & ~md_done_o.
- Latency: the regular path asserts md_done_o exactly XLEN+1 cycles after the first cycle is_md is seen; the special-case path asserts it 1 cycle after.
- Upstream holds funct_i, src*_i and valid_i stable while md_stall_o=1. The pipeline advances on the DONE edge, so the next instruction is seen in IDLE.
- Back-to-back M-ops: the second op starts in the cycle after DONE, with no bubble beyond that.

Signed handling:
- DIV quotient sign = sign1^sign2; REM sign = sign of dividend.
- MULH uses the sign of both operands; MULHSU uses src1's sign only.

flush_i:
- Any state -> IDLE at the next edge. No md_done_o pulse; md_result_o unchanged.
- flush_i has priority over a same-cycle start and over CALC->DONE.

rst_i:
- State IDLE, counter 0, md_result_o 0, md_done_o 0.
- Reset mid-operation discards the op with no pulse.
- rst_i has priority over flush_i.

md_result_o holds its value until the next DONE.

Test Plan:
- Decode sweep: ALUOp 10 with funct 0100000_000 -> 0010; 0000000_111 -> 0011; 0100000_101 -> 1001; 0000001_xxx -> 1111; ALUOp 01 -> 0010; ALUOp 11 -> 0001; funct7 1111111 with ALUOp 10 -> 0001.
- MUL 7 × 0xFFFFFFFD (-3), XLEN=32 -> stall high cycles 0..32, md_done_o at cycle 33, result 0xFFFFFFEB; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF(-1) × 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14, REMU -> 2; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, each done at cycle 33.
- Special cases: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0; each with done at cycle 1 and stall only in cycle 0.
- Abort: flush_i at cycle 10 of a DIVU -> no done pulse, IDLE next cycle, a following MUL 3×4 -> 12 on schedule. Repeat with rst_i pulsed at cycle 5 -> md_result_o=0, no pulse.
